// File: rtl/huffman_stream_ctrl_pkg.sv
// Shared types and constants for the byte-stream front end of the bit-serial Huffman decoder.
package huffman_stream_ctrl_pkg;

  localparam int unsigned MAX_CODE_LEN = 4;
  localparam int unsigned SYM_W        = 3;

  typedef enum logic [1:0] {PAUSE, REPLAY, RUN, DRAIN} ctrl_state_t;

  // True when the prefix held so far (cnt bits, newest bit 'last') plus bit b is a full code.
  function automatic logic code_done(input logic [1:0] cnt, input logic last, input logic b);
    case (cnt)
      2'd0:    code_done = !b;
      2'd1:    code_done = 1'b0;
      2'd2:    code_done = last ? !b : 1'b1;
      default: code_done = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/huffman_decoder.sv
// Bit-serial Moore Huffman decoder: one code bit per clock, y shows the symbol in leaf states.
module huffman_decoder
  import huffman_stream_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  output logic [SYM_W-1:0] y
);

  typedef enum logic [3:0] {S00, N1, N10, N11, N111, L1, L2, L3, L4, L5, L6} dec_state_t;

  dec_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S00;
    end else begin
      case (state)
        N1:      state <= x ? N11  : N10;
        N10:     state <= x ? L2   : L3;
        N11:     state <= x ? N111 : L4;
        N111:    state <= x ? L5   : L6;
        default: state <= x ? N1   : L1;  // root and every leaf restart the tree
      endcase
    end
  end

  always_comb begin
    y = '0;
    case (state)
      L1:      y = 3'd1;
      L2:      y = 3'd2;
      L3:      y = 3'd3;
      L4:      y = 3'd4;
      L5:      y = 3'd5;
      L6:      y = 3'd6;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/huffman_stream_ctrl.sv
// Serialises bytes MSB-first into huffman_decoder and buffers decoded symbols in a small FIFO.
module huffman_stream_ctrl
  import huffman_stream_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] sym,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  ctrl_state_t             state;
  logic                    pause_q;
  logic [7:0]              sr;
  logic [3:0]              bit_cnt;
  logic [MAX_CODE_LEN-2:0] rep_bits;
  logic [1:0]              rep_cnt;
  logic [1:0]              rp_cnt;
  logic [SYM_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count;

  logic             dec_x, dec_reset;
  logic [SYM_W-1:0] dec_y;
  logic             leaf, feed_sr, push, pop, accept, can_feed, keep_run, leaf_next;
  logic [3:0]       bit_cnt_nx;
  logic [1:0]       eff_cnt;

  huffman_decoder u_dec (
    .clk   (clk),
    .reset (dec_reset),
    .x     (dec_x),
    .y     (dec_y)
  );

  assign dec_reset = reset | pause_q;
  assign leaf      = (dec_y != '0);
  assign feed_sr   = (state == RUN);
  assign push      = leaf && !dec_reset;
  assign sym_valid = (fifo_count != '0);
  assign pop       = sym_valid && sym_ready;
  assign sym       = sym_valid ? mem[rd_ptr] : '0;
  assign busy      = (bit_cnt != '0) || (rep_cnt != '0) || sym_valid;

  assign in_ready   = (bit_cnt == 4'd0) || ((bit_cnt == 4'd1) && feed_sr);
  assign accept     = in_valid && in_ready;
  assign bit_cnt_nx = accept ? 4'd8 : (bit_cnt - {3'b000, feed_sr});

  // Pops are deliberately ignored so a symbol in flight always has a free slot.
  assign can_feed = (bit_cnt != 4'd0) &&
                    (32'(fifo_count) + 32'(leaf) + 32'd1 <= FIFO_DEPTH);

  // The tracker mirrors the decoder's tree position, so it predicts next cycle's leaf exactly.
  assign eff_cnt   = leaf ? 2'd0 : rep_cnt;
  assign leaf_next = code_done(eff_cnt, rep_bits[0], sr[7]);
  assign keep_run  = (bit_cnt_nx != 4'd0) &&
                     (32'(fifo_count) + 32'(push) + 32'(leaf_next) + 32'd1 <= FIFO_DEPTH);

  always_comb begin
    dec_x = 1'b0;
    case (state)
      RUN:     dec_x = sr[7];
      REPLAY:  dec_x = rep_bits[rp_cnt - 2'd1];
      default: dec_x = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PAUSE;
      pause_q    <= 1'b1;
      sr         <= '0;
      bit_cnt    <= '0;
      rep_bits   <= '0;
      rep_cnt    <= '0;
      rp_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept)       sr <= in_data;
      else if (feed_sr) sr <= {sr[6:0], 1'b0};
      bit_cnt <= bit_cnt_nx;

      if (push) begin
        mem[wr_ptr] <= dec_y;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        PAUSE: begin
          if (can_feed) begin
            pause_q <= 1'b0;
            if (rep_cnt != 2'd0) begin
              state  <= REPLAY;
              rp_cnt <= rep_cnt;
            end else begin
              state <= RUN;
            end
          end
        end
        REPLAY: begin
          rp_cnt <= rp_cnt - 2'd1;
          if (rp_cnt == 2'd1) state <= RUN;
        end
        RUN: begin
          if (leaf) begin
            rep_bits <= {{(MAX_CODE_LEN-2){1'b0}}, sr[7]};
            rep_cnt  <= 2'd1;
          end else begin
            rep_bits <= {rep_bits[MAX_CODE_LEN-3:0], sr[7]};
            rep_cnt  <= (rep_cnt == 2'd3) ? 2'd3 : rep_cnt + 2'd1;
          end
          if (!keep_run) state <= DRAIN;
        end
        default: begin
          if (leaf) begin
            rep_bits <= '0;
            rep_cnt  <= '0;
          end
          state   <= PAUSE;
          pause_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Randomised bench for huffman_stream_ctrl against a table-driven prefix-code reference model.
module tb_huffman_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] sym;
  logic       sym_valid;
  logic       sym_ready = 1'b0;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pops = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random
  int exp_q[$];
  int m_code = 0;
  int m_len = 0;

  huffman_stream_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int code_sym(input int code, input int len);
    if (len == 1 && code == 0) return 1;
    if (len == 3 && code == 4) return 3;
    if (len == 3 && code == 5) return 2;
    if (len == 3 && code == 6) return 4;
    if (len == 4 && code == 14) return 6;
    if (len == 4 && code == 15) return 5;
    return 0;
  endfunction

  task automatic model_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      int s;
      m_code = m_code * 2 + int'(w[i]);
      m_len++;
      s = code_sym(m_code, m_len);
      if (s != 0) begin
        exp_q.push_back(s);
        m_code = 0;
        m_len  = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       sym_ready = 1'b0;
        1:       sym_ready = 1'b1;
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset && sym_valid && sym_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("sym_extra", 32'(sym), 32'd0);
      else                   chk("sym", 32'(sym), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [7:0] w, input bit keep, output int acc);
    acc = -1;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        acc = cyc;
        model_word(w);
        step(1);
        break;
      end
      step(1);
    end
    if (!keep) in_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (10) @(negedge clk);
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'(m_len != 0));
    chk("valid_idle", 32'(sym_valid), 32'd0);
    step(1);
  endtask

  initial begin
    int acc, acc2, first, p0;

    step(3);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sym", 32'(sym), 32'd0);
    chk("rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    rdy_mode = 1;
    step(2);

    // 0x00: eight 1s, first symbol four cycles after acceptance
    p0 = pops;
    send_word(8'h00, 1'b0, acc);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sym_valid) begin
        first = cyc;
        break;
      end
    end
    chk("latency", 32'(first - acc), 32'd4);
    wait_drain();
    chk("cnt_00", 32'(pops - p0), 32'd8);

    rdy_mode = 2;
    p0 = pops;
    send_word(8'hEF, 1'b0, acc);
    wait_drain();
    chk("cnt_ef", 32'(pops - p0), 32'd2);

    // partial "11" must survive the idle gap
    p0 = pops;
    send_word(8'h97, 1'b0, acc);
    step(5);
    send_word(8'h00, 1'b0, acc);
    wait_drain();
    chk("cnt_97_00", 32'(pops - p0), 32'd10);

    // output stalled: FIFO fills, input must be held off
    rdy_mode = 0;
    step(3);
    p0 = pops;
    send_word(8'h00, 1'b0, acc);
    step(30);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(sym_valid), 32'd1);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_nopop", 32'(pops - p0), 32'd0);
    rdy_mode = 1;
    wait_drain();
    chk("cnt_full", 32'(pops - p0), 32'd8);

    // back-to-back words: second accepted exactly nine cycles after the first
    step(3);
    p0 = pops;
    send_word(8'h55, 1'b1, acc);
    send_word(8'hAA, 1'b0, acc2);
    chk("b2b_gap", 32'(acc2 - acc), 32'd9);
    wait_drain();
    chk("cnt_b2b", 32'(pops - p0), 32'd8);

    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      send_word(8'($urandom), 1'b0, acc);
      step($urandom_range(0, 3));
    end
    wait_drain();

    // reset in the middle of a code with a symbol already buffered
    rdy_mode = 0;
    step(3);
    send_word(8'h97, 1'b0, acc);
    step(5);
    reset = 1'b1;
    step(1);
    exp_q.delete();
    m_code = 0;
    m_len  = 0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sym", 32'(sym), 32'd0);
    reset = 1'b0;
    rdy_mode = 1;
    step(2);
    p0 = pops;
    send_word(8'h00, 1'b0, acc);
    wait_drain();
    chk("cnt_after_rst", 32'(pops - p0), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
